// File: rtl/msb_decode_32bit_pkg.sv
// rtl/msb_decode_32bit_pkg.sv - shared MSB position-code types and constants
package msb_pkg;

  localparam int POS_W  = 6;
  localparam int DATA_W = 32;

  typedef logic [POS_W-1:0]  pos_t;
  typedef logic [DATA_W-1:0] word_t;

  // Code 0 means "no bit set"; codes above POS_MAX are illegal
  localparam pos_t POS_NONE = 6'd0;
  localparam pos_t POS_MAX  = 6'd32;

  function automatic logic pos_is_legal(input pos_t pos);
    return pos <= POS_MAX;
  endfunction

endpackage

// File: rtl/msb_decode_32bit_if.sv
// rtl/msb_decode_32bit_if.sv - handshake bundle for msb_decode_32bit (MSB_DEC_THERMO_EN adds thermo_num)
interface msb_decode_32bit_if #(
  parameter int ERR_CNT_W = 8
);
  import msb_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  pos_t                 input_pos;
  logic                 out_valid;
  logic                 out_ready;
  word_t                output_num;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_cnt;
`ifdef MSB_DEC_THERMO_EN
  word_t                thermo_num;
`endif

`ifdef MSB_DEC_THERMO_EN
  modport master (
    output in_valid, input_pos, out_ready,
    input  in_ready, out_valid, output_num, out_err, err_cnt, thermo_num
  );
  modport slave (
    input  in_valid, input_pos, out_ready,
    output in_ready, out_valid, output_num, out_err, err_cnt, thermo_num
  );
`else
  modport master (
    output in_valid, input_pos, out_ready,
    input  in_ready, out_valid, output_num, out_err, err_cnt
  );
  modport slave (
    input  in_valid, input_pos, out_ready,
    output in_ready, out_valid, output_num, out_err, err_cnt
  );
`endif

endinterface

// File: rtl/msb_decode_32bit_pos_onehot_dec.sv
// rtl/msb_decode_32bit_pos_onehot_dec.sv - combinational position code to one-hot/thermometer decoder (MSB_DEC_THERMO_EN)
module pos_onehot_dec
  import msb_pkg::*;
(
  input  pos_t  pos_i,
  output word_t onehot_o,
`ifdef MSB_DEC_THERMO_EN
  output word_t thermo_o,
`endif
  output logic  err_o
);

  // Code k selects bit k-1; code 0 and illegal codes yield an all-zero word
  always_comb begin
    onehot_o = '0;
    err_o    = 1'b0;
    if (!pos_is_legal(pos_i)) begin
      err_o = 1'b1;
    end else if (pos_i != POS_NONE) begin
      onehot_o = word_t'(1) << (pos_i - pos_t'(1));
    end
  end

`ifdef MSB_DEC_THERMO_EN
  // Fill every bit below the one-hot bit; avoids a 33-bit (1<<32)-1 for code 32
  always_comb begin
    thermo_o = '0;
    if (onehot_o != '0) begin
      thermo_o = onehot_o | (onehot_o - word_t'(1));
    end
  end
`endif

endmodule

// File: rtl/msb_decode_32bit.sv
// rtl/msb_decode_32bit.sv - 2-stage MSB position decoder with valid/ready and error counter (MSB_DEC_THERMO_EN)
module msb_decode_32bit
  import msb_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  msb_decode_32bit_if.slave bus
);

  localparam logic [ERR_CNT_W-1:0] CNT_SAT = {ERR_CNT_W{1'b1}};

  logic                 s1_adv;
  logic                 s2_adv;

  logic                 s1_valid_q, s1_valid_d;
  pos_t                 s1_pos_q,   s1_pos_d;
  logic                 s2_valid_q, s2_valid_d;
  word_t                num_q,      num_d;
  logic                 err_q,      err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;

  word_t                dec_onehot;
  logic                 dec_err;
`ifdef MSB_DEC_THERMO_EN
  word_t                dec_thermo;
  word_t                thermo_q,   thermo_d;
`endif

  pos_onehot_dec u_dec (
    .pos_i    (s1_pos_q),
    .onehot_o (dec_onehot),
`ifdef MSB_DEC_THERMO_EN
    .thermo_o (dec_thermo),
`endif
    .err_o    (dec_err)
  );

  // Ready chain: a stage may advance when it is empty or the stage after it is moving
  always_comb begin
    s2_adv = !s2_valid_q || bus.out_ready;
    s1_adv = !s1_valid_q || s2_adv;
  end

  // Next-state for both pipeline stages and the saturating error counter
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_pos_d   = s1_pos_q;
    s2_valid_d = s2_valid_q;
    num_d      = num_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
`ifdef MSB_DEC_THERMO_EN
    thermo_d   = thermo_q;
`endif

    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_pos_d = bus.input_pos;
      end
    end

    // Output data only moves when stage 2 actually takes a new item, so a stall holds it
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        num_d    = dec_onehot;
        err_d    = dec_err;
`ifdef MSB_DEC_THERMO_EN
        thermo_d = dec_thermo;
`endif
      end
    end

    if (s2_valid_q && bus.out_ready && err_q && (err_cnt_q != CNT_SAT)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // State registers; reset drops anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_pos_q   <= POS_NONE;
      s2_valid_q <= 1'b0;
      num_q      <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
`ifdef MSB_DEC_THERMO_EN
      thermo_q   <= '0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_pos_q   <= s1_pos_d;
      s2_valid_q <= s2_valid_d;
      num_q      <= num_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
`ifdef MSB_DEC_THERMO_EN
      thermo_q   <= thermo_d;
`endif
    end
  end

  assign bus.in_ready   = s1_adv;
  assign bus.out_valid  = s2_valid_q;
  assign bus.output_num = num_q;
  assign bus.out_err    = err_q;
  assign bus.err_cnt    = err_cnt_q;
`ifdef MSB_DEC_THERMO_EN
  assign bus.thermo_num = thermo_q;
`endif

endmodule

// File: tb/tb_msb_decode_32bit.sv
// tb/tb_msb_decode_32bit.sv - randomized self-checking bench for msb_decode_32bit (MSB_DEC_THERMO_EN)
module tb_msb_decode_32bit;
  import msb_pkg::*;

  localparam int CNT_MAX = 255;

  typedef struct {
    word_t num;
    logic  err;
    word_t thermo;
  } item_t;

  logic clk;
  logic rst_n;

  msb_decode_32bit_if #(.ERR_CNT_W(8)) bus ();

  msb_decode_32bit #(.ERR_CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  item_t exp_q[$];
  item_t exp_item;
  int    model_cnt = 0;
  int    inflight;
  logic  acc, del;
  logic  obs_in_ready, obs_out_valid, obs_err;
  word_t obs_num, obs_thermo;
  int    obs_cnt;

  // Reference: the position code names the MSB; build the word with plain powers of two
  function automatic item_t ref_model(input int code);
    item_t   it;
    longint  p;
    it.num = '0; it.err = 1'b0; it.thermo = '0;
    if (code > 32) begin
      it.err = 1'b1;
    end else if (code > 0) begin
      p = longint'(1) << (code - 1);
      it.num    = word_t'(p);
      it.thermo = word_t'(2 * p - 1);
    end
    return it;
  endfunction

  // One clock: drive, sample at negedge, update scoreboard, return just after posedge
  task automatic tick(input logic v, input int p, input logic ordy);
    bus.in_valid  = v;
    bus.input_pos = pos_t'(p);
    bus.out_ready = ordy;
    @(negedge clk);
    obs_in_ready  = bus.in_ready;
    obs_out_valid = bus.out_valid;
    obs_num       = bus.output_num;
    obs_err       = bus.out_err;
    obs_cnt       = int'(bus.err_cnt);
`ifdef MSB_DEC_THERMO_EN
    obs_thermo    = bus.thermo_num;
`else
    obs_thermo    = '0;
`endif
    inflight = exp_q.size();
    acc = v && obs_in_ready;
    del = obs_out_valid && ordy;
    if (del) begin
      if (exp_q.size() == 0) begin
        exp_item.num = 'x; exp_item.err = 1'bx; exp_item.thermo = 'x;
      end else begin
        exp_item = exp_q.pop_front();
        if (exp_item.err && model_cnt < CNT_MAX) model_cnt++;
      end
    end
    if (acc) exp_q.push_back(ref_model(p));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.input_pos = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.output_num !== 32'h0) begin bad++; $display("FAIL reset_output_num got=%h want=0", bus.output_num); end
    total++; if (bus.out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%b want=0", bus.out_err); end
    total++; if (bus.err_cnt !== 8'h0) begin bad++; $display("FAIL reset_err_cnt got=%h want=0", bus.err_cnt); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
`ifdef MSB_DEC_THERMO_EN
    total++; if (bus.thermo_num !== 32'h0) begin bad++; $display("FAIL reset_thermo got=%h want=0", bus.thermo_num); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_round_trip;
    logic [31:0] src;
    int code;
    src = 32'h3100_3131;
    code = 0;
    for (int i = 0; i < 32; i++) if (src[i]) code = i + 1;
    tick(1'b1, code, 1'b1);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL rt_accept got=%b want=1", acc); end
    tick(1'b0, 0, 1'b1);
    total++; if (obs_out_valid !== 1'b0) begin bad++; $display("FAIL rt_early_valid got=%b want=0", obs_out_valid); end
    tick(1'b0, 0, 1'b1);
    total++; if (obs_out_valid !== 1'b1) begin bad++; $display("FAIL rt_latency got=%b want=1", obs_out_valid); end
    total++; if (obs_num !== 32'h2000_0000) begin bad++; $display("FAIL rt_num got=%h want=20000000", obs_num); end
    total++; if (obs_err !== 1'b0) begin bad++; $display("FAIL rt_err got=%b want=0", obs_err); end
  endtask

  task automatic test_back_to_back;
    int    codes[4];
    word_t want[4];
    codes = '{14, 1, 32, 0};
    want  = '{32'h0000_2000, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000};
    for (int i = 0; i < 6; i++) begin
      tick(i < 4, (i < 4) ? codes[i] : 0, 1'b1);
      if (i < 4) begin
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL b2b_accept%0d got=%b want=1", i, acc); end
      end
      if (i >= 2) begin
        total++; if (del !== 1'b1) begin bad++; $display("FAIL b2b_deliver%0d got=%b want=1", i - 2, del); end
        total++; if (obs_num !== want[i-2]) begin bad++; $display("FAIL b2b_num%0d got=%h want=%h", i - 2, obs_num, want[i-2]); end
        total++; if (obs_err !== 1'b0) begin bad++; $display("FAIL b2b_err%0d got=%b want=0", i - 2, obs_err); end
      end
    end
  endtask

  task automatic test_errors;
    int sent, n;
    tick(1'b1, 33, 1'b1);
    tick(1'b1, 63, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 0, 1'b1);
      total++; if (del !== 1'b1) begin bad++; $display("FAIL err_deliver%0d got=%b want=1", i, del); end
      total++; if (obs_num !== 32'h0) begin bad++; $display("FAIL err_num%0d got=%h want=0", i, obs_num); end
      total++; if (obs_err !== 1'b1) begin bad++; $display("FAIL err_flag%0d got=%b want=1", i, obs_err); end
    end
    tick(1'b0, 0, 1'b1);
    total++; if (obs_cnt !== 2) begin bad++; $display("FAIL err_cnt_two got=%0d want=2", obs_cnt); end
    sent = 0; n = 0;
    while (sent < 300 && n < 3000) begin
      tick(1'b1, int'($urandom_range(33, 63)), ($urandom % 4) != 0);
      if (acc) sent++;
      if (del) begin
        total++; if (obs_err !== 1'b1 || obs_num !== 32'h0) begin bad++; $display("FAIL err_stream got=%h/%b want=0/1", obs_num, obs_err); end
      end
      n++;
    end
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin tick(1'b0, 0, 1'b1); n++; end
    tick(1'b0, 0, 1'b1);
    total++; if (sent !== 300 || exp_q.size() != 0) begin bad++; $display("FAIL err_drain got=%0d/%0d want=300/0", sent, exp_q.size()); end
    total++; if (obs_cnt !== 255) begin bad++; $display("FAIL err_cnt_sat got=%0d want=255", obs_cnt); end
  endtask

  task automatic test_stall;
    int    codes[5];
    int    sent, got, t;
    logic  ordy, prev_stall, saw_block;
    word_t prev_num;
    for (int i = 0; i < 5; i++) codes[i] = int'($urandom_range(0, 32));
    sent = 0; got = 0; t = 0; prev_stall = 1'b0; saw_block = 1'b0; prev_num = '0;
    while (got < 5 && t < 40) begin
      ordy = !(t >= 3 && t < 6);
      tick(sent < 5, (sent < 5) ? codes[sent] : 0, ordy);
      if (acc) sent++;
      total++; if (obs_in_ready !== !(inflight == 2 && !ordy)) begin bad++; $display("FAIL stall_in_ready t=%0d got=%b want=%b", t, obs_in_ready, !(inflight == 2 && !ordy)); end
      if (!obs_in_ready) saw_block = 1'b1;
      if (prev_stall) begin
        total++; if (obs_out_valid !== 1'b1 || obs_num !== prev_num) begin bad++; $display("FAIL stall_hold t=%0d got=%h want=%h", t, obs_num, prev_num); end
      end
      if (del) begin
        got++;
        total++; if (obs_num !== exp_item.num || obs_err !== exp_item.err) begin bad++; $display("FAIL stall_data t=%0d got=%h want=%h", t, obs_num, exp_item.num); end
      end
      prev_stall = obs_out_valid && !ordy;
      prev_num   = obs_num;
      t++;
    end
    total++; if (got !== 5 || exp_q.size() != 0) begin bad++; $display("FAIL stall_count got=%0d/%0d want=5/0", got, exp_q.size()); end
    total++; if (saw_block !== 1'b1) begin bad++; $display("FAIL stall_block got=%b want=1", saw_block); end
  endtask

  task automatic test_random;
    int n;
    logic ordy;
    for (int t = 0; t < 400; t++) begin
      ordy = ($urandom % 3) != 0;
      tick(($urandom % 4) != 0, int'($urandom_range(0, 63)), ordy);
      total++; if (obs_in_ready !== !(inflight == 2 && !ordy)) begin bad++; $display("FAIL rand_in_ready t=%0d got=%b", t, obs_in_ready); end
      if (del) begin
        total++; if (obs_num !== exp_item.num || obs_err !== exp_item.err) begin bad++; $display("FAIL rand_data t=%0d got=%h/%b want=%h/%b", t, obs_num, obs_err, exp_item.num, exp_item.err); end
`ifdef MSB_DEC_THERMO_EN
        total++; if (obs_thermo !== exp_item.thermo) begin bad++; $display("FAIL rand_thermo t=%0d got=%h want=%h", t, obs_thermo, exp_item.thermo); end
`endif
      end
    end
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      tick(1'b0, 0, 1'b1);
      if (del) begin
        total++; if (obs_num !== exp_item.num || obs_err !== exp_item.err) begin bad++; $display("FAIL rand_drain got=%h want=%h", obs_num, exp_item.num); end
      end
      n++;
    end
    tick(1'b0, 0, 1'b1);
    total++; if (exp_q.size() != 0 || obs_out_valid !== 1'b0) begin bad++; $display("FAIL rand_empty got=%0d/%b want=0/0", exp_q.size(), obs_out_valid); end
    total++; if (obs_cnt !== model_cnt) begin bad++; $display("FAIL rand_err_cnt got=%0d want=%0d", obs_cnt, model_cnt); end
  endtask

`ifdef MSB_DEC_THERMO_EN
  task automatic test_thermo;
    word_t want[2];
    int    got;
    want = '{32'h0000_3FFF, 32'hFFFF_FFFF};
    got = 0;
    tick(1'b1, 14, 1'b1);
    tick(1'b1, 32, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 0, 1'b1);
      if (del && got < 2) begin
        total++; if (obs_thermo !== want[got]) begin bad++; $display("FAIL thermo%0d got=%h want=%h", got, obs_thermo, want[got]); end
        got++;
      end
    end
    total++; if (got !== 2) begin bad++; $display("FAIL thermo_count got=%0d want=2", got); end
  endtask
`endif

  task automatic test_reset_inflight;
    tick(1'b1, int'($urandom_range(1, 32)), 1'b0);
    tick(1'b1, int'($urandom_range(33, 63)), 1'b0);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rst_fill got=%b want=1", bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.err_cnt !== 8'h0) begin bad++; $display("FAIL rst_err_cnt got=%h want=0", bus.err_cnt); end
    total++; if (bus.output_num !== 32'h0) begin bad++; $display("FAIL rst_output_num got=%h want=0", bus.output_num); end
    exp_q.delete();
    model_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 0, 1'b1);
      total++; if (obs_out_valid !== 1'b0) begin bad++; $display("FAIL rst_stale%0d got=%b want=0", i, obs_out_valid); end
    end
    tick(1'b1, 5, 1'b1);
    tick(1'b0, 0, 1'b1);
    tick(1'b0, 0, 1'b1);
    total++; if (obs_out_valid !== 1'b1 || obs_num !== 32'h0000_0010) begin bad++; $display("FAIL rst_recover got=%h want=00000010", obs_num); end
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_back_to_back();
    test_errors();
    test_stall();
    test_random();
`ifdef MSB_DEC_THERMO_EN
    test_thermo();
`endif
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
